// File: rtl/count_seq_checker.sv
// Checks an up/down counter's q (and optionally qb) against the value implied by the previous sample.
// Define QB_CHECK_EN to also flag samples where qb is not the bitwise complement of q.
//
// state | meaning
// IDLE  | capture a reference sample, no comparison this edge
// TRACK | compare every sample against the expected step, count mismatches
// FAULT | error limit reached; comparison stopped, err/err_cnt held until clr
module count_seq_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             up_down,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] qb,
    input  logic             clr,
    output logic             err,
    output logic             err_pulse,
    output logic [7:0]       err_cnt,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] Q_MAX = '1;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] q_prev;
    logic             en_prev;
    logic             dir_prev;
    logic [WIDTH-1:0] q_exp;
    logic             qb_bad;
    logic             mismatch;
    logic [7:0]       cnt_inc;
    logic             err_nxt;
    logic             err_pulse_nxt;
    logic [7:0]       err_cnt_nxt;
    logic             wrap_up_nxt;
    logic             wrap_dn_nxt;

`ifdef QB_CHECK_EN
    assign qb_bad = (qb != ~q);
`else
    // qb is deliberately ignored in this build; the reduction feeds nothing.
    logic unused_qb;
    assign unused_qb = ^qb;
    assign qb_bad    = 1'b0;
`endif

    always_comb begin
        q_exp = q_prev;
        if (en_prev) begin
            q_exp = dir_prev ? (q_prev + Q_ONE) : (q_prev - Q_ONE);
        end
    end

    // A q fault and a qb fault in the same sample collapse into one mismatch.
    assign mismatch = (q != q_exp) || qb_bad;
    assign cnt_inc  = (err_cnt == 8'hFF) ? err_cnt : (err_cnt + 8'd1);

    always_comb begin
        state_nxt     = state_q;
        err_nxt       = err;
        err_cnt_nxt   = err_cnt;
        err_pulse_nxt = 1'b0;
        wrap_up_nxt   = 1'b0;
        wrap_dn_nxt   = 1'b0;
        if (clr) begin
            state_nxt   = IDLE;
            err_nxt     = 1'b0;
            err_cnt_nxt = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_nxt = TRACK;
                end
                TRACK: begin
                    if (mismatch) begin
                        err_pulse_nxt = 1'b1;
                        err_nxt       = 1'b1;
                        err_cnt_nxt   = cnt_inc;
                        if (32'(cnt_inc) >= ERR_LIMIT) begin
                            state_nxt = FAULT;
                        end
                    end else begin
                        wrap_up_nxt = en_prev &  dir_prev & (q_prev == Q_MAX) & (q == '0);
                        wrap_dn_nxt = en_prev & ~dir_prev & (q_prev == '0) & (q == Q_MAX);
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            q_prev    <= '0;
            en_prev   <= 1'b0;
            dir_prev  <= 1'b0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= 8'd0;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            // History always follows the observed q, so tracking resyncs after a glitch.
            q_prev    <= q;
            en_prev   <= t;
            dir_prev  <= up_down;
            err       <= err_nxt;
            err_pulse <= err_pulse_nxt;
            err_cnt   <= err_cnt_nxt;
            wrap_up   <= wrap_up_nxt;
            wrap_dn   <= wrap_dn_nxt;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: directed scenarios plus randomized counter traffic
// with injected q/qb glitches, clears and async resets, checked against an integer reference model.
module tb_count_seq_checker;

    localparam int WIDTH     = 4;
    localparam int ERR_LIMIT = 4;
    localparam int MODV      = 1 << WIDTH;
`ifdef QB_CHECK_EN
    localparam int QB_EXP = 1;
`else
    localparam int QB_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             t = 1'b0;
    logic             up_down = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] q = '0;
    logic [WIDTH-1:0] qb = '1;
    logic             err;
    logic             err_pulse;
    logic [7:0]       err_cnt;
    logic             wrap_up;
    logic             wrap_dn;
    logic [1:0]       state;

    count_seq_checker #(.WIDTH(WIDTH), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk(clk), .rst(rst), .t(t), .up_down(up_down), .q(q), .qb(qb), .clr(clr),
        .err(err), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .wrap_up(wrap_up), .wrap_dn(wrap_dn), .state(state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: mode 0 = waiting for reference, 1 = tracking, 2 = fault
    int m_mode, m_cnt, m_qp;
    bit m_err, m_pulse, m_wu, m_wd, m_en, m_dir;
    int cur_q;
    int n_wu, n_wd, n_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int step_of(input int v, input bit en, input bit dir);
        if (!en) return v;
        return dir ? (v + 1) % MODV : (v + MODV - 1) % MODV;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_qp = 0;
        m_err = 0; m_pulse = 0; m_wu = 0; m_wd = 0; m_en = 0; m_dir = 0;
    endtask

    task automatic model_step();
        int  qv, exp_q;
        bit  bad;
        qv = int'(q);
        m_pulse = 0; m_wu = 0; m_wd = 0;
        if (clr) begin
            m_mode = 0; m_cnt = 0; m_err = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            exp_q = step_of(m_qp, m_en, m_dir);
            bad = (qv != exp_q);
`ifdef QB_CHECK_EN
            if (int'(qb) != MODV - 1 - qv) bad = 1;
`endif
            if (bad) begin
                m_pulse = 1;
                m_err = 1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                if (m_cnt >= ERR_LIMIT) m_mode = 2;
            end else begin
                m_wu = m_en && m_dir && m_qp == MODV - 1 && qv == 0;
                m_wd = m_en && !m_dir && m_qp == 0 && qv == MODV - 1;
            end
        end
        m_qp = qv; m_en = t; m_dir = up_down;
    endtask

    task automatic check_outputs();
        check("state", 32'(state), 32'(m_mode));
        check("err", 32'(err), 32'(m_err));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("wrap_up", 32'(wrap_up), 32'(m_wu));
        check("wrap_dn", 32'(wrap_dn), 32'(m_wd));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit t_i, input bit dir_i, input bit clr_i, input int q_i, input int qb_i);
        t = t_i; up_down = dir_i; clr = clr_i;
        q = WIDTH'(q_i); qb = WIDTH'(qb_i);
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        n_wu += int'(wrap_up); n_wd += int'(wrap_dn); n_pulse += int'(err_pulse);
        cur_q = step_of(q_i, t_i, dir_i);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit t_i, input bit dir_i);
        for (int i = 0; i < n; i++) cycle(t_i, dir_i, 1'b0, cur_q, MODV - 1 - cur_q);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < MODV && cur_q != target; i++) run(1, 1'b1, 1'b1);
        check("run_to", 32'(cur_q), 32'(target));
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_wrap_up", 32'(wrap_up), 32'd0);
        check("rst_wrap_dn", 32'(wrap_dn), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        model_reset();
        cur_q = 0;
        #12;
        check("init_state", 32'(state), 32'd0);
        check("init_err", 32'(err), 32'd0);
        check("init_err_cnt", 32'(err_cnt), 32'd0);
        check("init_pulse", 32'(err_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // full count up through 15->0
        n_wu = 0; n_pulse = 0;
        run(18, 1'b1, 1'b1);
        check("up_wrap_count", 32'(n_wu), 32'd1);
        check("up_err_cnt", 32'(err_cnt), 32'd0);
        check("up_err", 32'(err), 32'd0);

        // count down through 0->15 (direction change mid-stream)
        n_wd = 0;
        run(4, 1'b1, 1'b0);
        check("dn_wrap_count", 32'(n_wd), 32'd1);
        check("dn_err", 32'(err), 32'd0);

        // single glitch 5->9, then resynchronised counting
        run_to(5);
        run(1, 1'b1, 1'b1);
        n_pulse = 0;
        cycle(1'b1, 1'b1, 1'b0, 9, MODV - 1 - 9);
        run(3, 1'b1, 1'b1);
        check("glitch_pulses", 32'(n_pulse), 32'd1);
        check("glitch_err_cnt", 32'(err_cnt), 32'd1);
        check("glitch_err", 32'(err), 32'd1);

        // error limit -> FAULT, held, then clr
        cycle(1'b1, 1'b1, 1'b1, cur_q, MODV - 1 - cur_q);
        check("clr_cnt", 32'(err_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            run(2, 1'b1, 1'b1);
            cycle(1'b1, 1'b1, 1'b0, (cur_q + 8) % MODV, MODV - 1 - (cur_q + 8) % MODV);
            if (k == 3) begin
                check("limit_state", 32'(state), 32'd2);
                check("limit_cnt", 32'(err_cnt), 32'(ERR_LIMIT));
            end
        end
        check("fault_hold_cnt", 32'(err_cnt), 32'(ERR_LIMIT));
        check("fault_hold_state", 32'(state), 32'd2);
        cycle(1'b1, 1'b1, 1'b1, cur_q, MODV - 1 - cur_q);
        check("clr_state", 32'(state), 32'd0);
        check("clr_cnt2", 32'(err_cnt), 32'd0);

        // qb forced to all-ones while q=3
        run(2, 1'b1, 1'b1);
        run_to(3);
        cycle(1'b1, 1'b1, 1'b0, 3, MODV - 1);
        check("qb_fault_cnt", 32'(err_cnt), 32'(QB_EXP));
        cycle(1'b1, 1'b1, 1'b1, cur_q, MODV - 1 - cur_q);

        // async reset mid-count at q=7
        run(2, 1'b1, 1'b1);
        run_to(7);
        do_reset();
        n_pulse = 0;
        run(3, 1'b1, 1'b1);
        check("post_rst_pulses", 32'(n_pulse), 32'd0);
        check("post_rst_cnt", 32'(err_cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            int r, qv, qbv;
            bit t_i, dir_i, clr_i;
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                do_reset();
            end else begin
                t_i   = ($urandom_range(0, 3) != 0);
                dir_i = 1'($urandom_range(0, 1));
                clr_i = (r < 4);
                qv    = cur_q;
                if (r >= 4 && r < 12) qv = int'($urandom_range(0, MODV - 1));
                qbv   = MODV - 1 - qv;
                if (r >= 12 && r < 17) qbv = int'($urandom_range(0, MODV - 1));
                cycle(t_i, dir_i, clr_i, qv, qbv);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
